// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// FSM state encoding, requester count and the default lane width.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NREQ      = 4;
  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/mux_41_4b.sv
// Plain combinational 4:1 multiplexer; {sel1,sel0} picks lane a..d.
module mux_41_4b #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sel1,
  input  logic             sel0,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case ({sel1, sel0})
      2'b00:   y = a;
      2'b01:   y = b;
      2'b10:   y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/mux_41_4b_arb.sv
// Round-robin arbiter over four requester lanes feeding a shared 4:1 mux.
// Define ARB_LOCK_EN to let lock[i] keep priority on the lane just served.
module mux_41_4b_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [3:0]       lock,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             sel1,
  output logic             sel0,
  output logic [3:0]       ack
);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt, winner, sel_q, mux_sel;
  logic             found, grant, xfer;
  logic [WIDTH-1:0] mux_y;

  // Search upward from ptr+1; the i=NREQ step lands back on ptr itself.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // The mux follows the live winner while idle so out_data can load on the grant edge.
  assign mux_sel = (state == IDLE) ? winner : sel_q;

  mux_41_4b #(.WIDTH(WIDTH)) u_mux (
    .a    (A),
    .b    (B),
    .c    (C),
    .d    (D),
    .sel1 (mux_sel[1]),
    .sel0 (mux_sel[0]),
    .y    (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: if (found) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (out_ready) begin
        xfer      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARB_LOCK_EN
  // Parking ptr one below the winner makes it the first lane searched next time.
  assign ptr_nxt = lock[sel_q] ? (sel_q - 2'd1) : sel_q;
`else
  logic lock_unused;
  assign lock_unused = ^lock;
  assign ptr_nxt     = sel_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sel_q    <= '0;
      ptr      <= 2'd3;
      ack      <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        sel_q    <= winner;
        out_data <= mux_y;
      end
      if (xfer) begin
        ack <= 4'b0001 << sel_q;
        ptr <= ptr_nxt;
      end
    end
  end

  assign out_valid = (state == BUSY);
  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];

endmodule

// File: tb/tb_mux_41_4b_arb.sv
// Directed, table-driven bench for mux_41_4b_arb with lanes A=1,B=2,C=4,D=8.
module tb_mux_41_4b_arb;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] es;
    logic [3:0] ea;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, lock, A, B, C, D, out_data, ack;
  logic       out_ready, out_valid, sel1, sel0;

  int total = 0;
  int bad   = 0;

  vec_t tab1[$];
  vec_t tab2[$];

  mux_41_4b_arb #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .lock      (lock),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel1      (sel1),
    .sel0      (sel0),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [3:0] r, logic rd, logic ev,
                              logic [3:0] ed, logic [1:0] es, logic [3:0] ea);
    vec_t v;
    v.name = n; v.req = r; v.rdy = rd; v.ev = ev; v.ed = ed; v.es = es; v.ea = ea;
    return v;
  endfunction

  task automatic cmp(input string n, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic rd, input logic [3:0] lk);
    req       = r;
    out_ready = rd;
    lock      = lk;
  endtask

  task automatic checkOutput(input string n, input logic ev, input logic [3:0] ed,
                             input logic [1:0] es, input logic [3:0] ea);
    cmp({n, ".valid"}, {3'b0, out_valid}, {3'b0, ev});
    cmp({n, ".data"},  out_data, ed);
    cmp({n, ".sel"},   {2'b0, sel1, sel0}, {2'b0, es});
    cmp({n, ".ack"},   ack, ea);
  endtask

  task automatic runTable(input vec_t t[$]);
    foreach (t[k]) begin
      applyStimulus(t[k].req, t[k].rdy, 4'b0000);
      @(negedge clk);
      checkOutput(t[k].name, t[k].ev, t[k].ed, t[k].es, t[k].ea);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lane;
    // idle after reset release
    for (int i = 0; i < 5; i++) tab1.push_back(mk("idle", 4'b0000, 1'b0, 0, 4'h0, 2'd0, 4'b0000));
    // full rotation from ptr=3: grant cycle then ack cycle per lane
    tab1.push_back(mk("rot0g", 4'b1111, 1, 1, 4'h1, 2'd0, 4'b0000));
    tab1.push_back(mk("rot0a", 4'b1111, 1, 0, 4'h1, 2'd0, 4'b0001));
    tab1.push_back(mk("rot1g", 4'b1111, 1, 1, 4'h2, 2'd1, 4'b0000));
    tab1.push_back(mk("rot1a", 4'b1111, 1, 0, 4'h2, 2'd1, 4'b0010));
    tab1.push_back(mk("rot2g", 4'b1111, 1, 1, 4'h4, 2'd2, 4'b0000));
    tab1.push_back(mk("rot2a", 4'b1111, 1, 0, 4'h4, 2'd2, 4'b0100));
    tab1.push_back(mk("rot3g", 4'b1111, 1, 1, 4'h8, 2'd3, 4'b0000));
    tab1.push_back(mk("rot3a", 4'b1111, 1, 0, 4'h8, 2'd3, 4'b1000));
    tab1.push_back(mk("wrapg", 4'b1111, 1, 1, 4'h1, 2'd0, 4'b0000));
    tab1.push_back(mk("wrapa", 4'b1111, 1, 0, 4'h1, 2'd0, 4'b0001));
    tab1.push_back(mk("quiet", 4'b0000, 1, 0, 4'h1, 2'd0, 4'b0000));
    // lane C alone, stalled downstream, req dropped while busy
    tab1.push_back(mk("holdg", 4'b0100, 0, 1, 4'h4, 2'd2, 4'b0000));
    tab1.push_back(mk("hold1", 4'b0100, 0, 1, 4'h4, 2'd2, 4'b0000));
    tab1.push_back(mk("hold2", 4'b1111, 0, 1, 4'h4, 2'd2, 4'b0000));
    tab1.push_back(mk("hold3", 4'b0000, 0, 1, 4'h4, 2'd2, 4'b0000));
    tab1.push_back(mk("holda", 4'b0000, 1, 0, 4'h4, 2'd2, 4'b0100));
    tab1.push_back(mk("hold4", 4'b0000, 1, 0, 4'h4, 2'd2, 4'b0000));
    // single requester B wins although ptr=2 searches 3,0,1
    tab1.push_back(mk("soleg", 4'b0010, 1, 1, 4'h2, 2'd1, 4'b0000));
    tab1.push_back(mk("solea", 4'b0010, 1, 0, 4'h2, 2'd1, 4'b0010));
    tab1.push_back(mk("sole0", 4'b0000, 1, 0, 4'h2, 2'd1, 4'b0000));
    // busy on lane B, left pending for the reset sequence
    tab1.push_back(mk("busyB", 4'b0010, 0, 1, 4'h2, 2'd1, 4'b0000));

    tab2.push_back(mk("rstg", 4'b1111, 0, 1, 4'h1, 2'd0, 4'b0000));
    tab2.push_back(mk("rsta", 4'b1111, 1, 0, 4'h1, 2'd0, 4'b0001));

    A = 4'h1; B = 4'h2; C = 4'h4; D = 4'h8;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0, 4'b0000);
    @(negedge clk);
    checkOutput("reset", 0, 4'h0, 2'd0, 4'b0000);
    rst_n = 1'b1;

    runTable(tab1);

    // async reset in the middle of a pending lane-B transfer
    rst_n = 1'b0;
    #1;
    checkOutput("rstnow", 0, 4'h0, 2'd0, 4'b0000);
    applyStimulus(4'b1111, 1'b1, 4'b0000);
    @(negedge clk);
    checkOutput("rsthold", 0, 4'h0, 2'd0, 4'b0000);
    rst_n = 1'b1;

    runTable(tab2);

    // lock hint on lane B: honoured only when the lock feature is built in
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_LOCK_EN
      lane = 1;
`else
      lane = (g + 1) % 4;
`endif
      applyStimulus(4'b1111, 1'b1, 4'b0010);
      @(negedge clk);
      checkOutput($sformatf("lockg%0d", g), 1, 4'(1 << lane), 2'(lane), 4'b0000);
      @(negedge clk);
      checkOutput($sformatf("locka%0d", g), 0, 4'(1 << lane), 2'(lane), 4'(1 << lane));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_41_4b_arb.md
MUX_41_4B_ARB -- requirements
Module: mux_41_4b_arb

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each requester lane and of out_data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester request; bit i = lane i (0=A, 1=B, 2=C, 3=D); held high until ack[i].
REQ-005 A, B, C, D  input  WIDTH each  requester data lanes 0..3; stable while the matching req is high.
REQ-006 lock  input  4  per-requester keep-priority hint; used only under ARB_LOCK_EN.
REQ-007 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-008 out_valid  output  1  out_data holds a granted lane's value.
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 sel1, sel0  output  1 each  encoded index of the current/last granted lane, driving the shared 4:1 mux.
REQ-011 ack  output  4  one-hot, one-cycle pulse to the served requester on transfer.

Function
REQ-012 FSM has two states: IDLE and BUSY.
REQ-013 IDLE, req==0: stay in IDLE; out_valid=0; ack=0.
REQ-014 IDLE, req!=0: pick the winner round-robin, searching upward from (ptr+1) mod 4; register {sel1,sel0}=winner and out_data=lane[winner]; go to BUSY. out_valid goes high the cycle after req is first sampled (latency 1).
REQ-015 BUSY: out_valid=1; out_data, sel1 and sel0 hold stable while out_ready=0, even if req changes.
REQ-016 BUSY with out_ready=1 is a transfer. On the next edge: ack[winner]=1 for one cycle; ptr<=winner; state<=IDLE.
REQ-017 One mandatory IDLE cycle follows every transfer, so peak throughput is one transfer per 2 cycles.
REQ-018 A requester that drops req while in BUSY is still served; the transfer completes normally.
REQ-019 Wrap-around: after lane 3 is served, search order is 0,1,2,3.
REQ-020 When only one lane requests, it wins regardless of ptr.
REQ-021 ack never has more than one bit set; out_valid never rises in the same cycle as an ack pulse.

Reset
REQ-022 While rst_n=0 (asynchronous): state=IDLE; out_valid=0; out_data=0; sel1=0; sel0=0; ack=0; ptr=3, so lane 0 has first priority.
REQ-023 Reset asserted mid-BUSY discards the pending transfer; no ack is issued.

Configuration
REQ-024 Macro ARB_LOCK_EN defined: at a transfer where lock[winner]=1, ptr<=winner-1 mod 4, so the same lane wins again next if it still requests.
REQ-025 ARB_LOCK_EN undefined: the lock port exists but is ignored; ptr always updates per REQ-016.

Structure
REQ-026 Shared package mux_arb_pkg holds: the state encoding (IDLE=0, BUSY=1), NREQ=4, and the WIDTH default.
REQ-027 Data selection instantiates the existing mux_41_4b sub-module with sel1/sel0 from the arbiter; its output is registered into out_data.
REQ-028 The round-robin pick is combinational logic inside this module; no further sub-modules.

Verification
REQ-029 Reset release, req=0000 for 5 cycles -> out_valid=0, ack=0000, sel1/sel0=00.
REQ-030 A=1,B=2,C=4,D=8, req=1111, out_ready=1 -> grant order 0,1,2,3,0; out_data 1,2,4,8,1; one ack pulse every 2 cycles.
REQ-031 req=0100 only, out_ready=0 for 3 cycles then 1 -> out_data=4 and sel=10 held stable; ack=0100 once, after the transfer.
REQ-032 BUSY on lane 1, rst_n pulsed low -> outputs reset immediately; no ack; next grant with req=1111 goes to lane 0.
REQ-033 ARB_LOCK_EN defined, req=1111, lock=0010 -> lane 1 wins repeatedly. Undefined -> rotation 0,1,2,3.
REQ-034 After a transfer with out_ready tied high -> out_valid low for exactly one cycle between grants.
